// File: rtl/ntt_ld_streamer.sv
// Load-side streamer: reads coefficient pairs from SRAM, packs them into beats and
// hands them to the NTT kernel through a 2-entry registered FIFO with credit-based reads.
module ntt_ld_streamer #(
   parameter int unsigned pDATA_WIDTH = 128,
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pLEN_WIDTH  = 12
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [pADDR_WIDTH-1:0]   base_addr,
   input  logic [pLEN_WIDTH-1:0]    num_beats,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_en,
   output logic [pADDR_WIDTH-1:0]   mem_addr,
   input  logic [pDATA_WIDTH/2-1:0] mem_rdata,
   output logic                     ld_vld,
   input  logic                     ld_rdy,
   output logic [pDATA_WIDTH-1:0]   ld_d
);

   localparam int unsigned WordWidth = pDATA_WIDTH / 2;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StFin   = 2'd3;

   localparam logic [pADDR_WIDTH-1:0] AddrOne = 1;
   localparam logic [pLEN_WIDTH-1:0]  LenOne  = 1;

   logic [1:0]             state_q, state_d;
   logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [pADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   // Beats whose low-word read has not been issued yet.
   logic [pLEN_WIDTH-1:0]  pairs_q, pairs_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_hi_q, mem_hi_d;
   logic                   rd_vld_q, rd_hi_q;
   logic [WordWidth-1:0]   lo_q;
   logic [1:0]             inflight_q, inflight_d;
   logic [1:0]             count_q, count_d;
   logic [pDATA_WIDTH-1:0] fifo_q [2];
   logic                   wr_ptr_q, rd_ptr_q;

   logic       push, pop, issue_lo, can_issue_lo;
   logic [2:0] credit;

   assign push   = rd_vld_q && rd_hi_q;
   assign ld_vld = (count_q != 2'd0);
   assign pop    = ld_vld && ld_rdy;
   assign ld_d   = fifo_q[rd_ptr_q];

   // A pop on this edge frees a slot long before the new pair's data can land.
   assign credit       = {1'b0, count_q} + {1'b0, inflight_q} - {2'b00, pop};
   assign can_issue_lo = (credit < 3'd2);

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StFin);
   assign mem_en   = mem_en_q;
   assign mem_addr = mem_addr_q;

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      mem_addr_d = mem_addr_q;
      pairs_d    = pairs_q;
      mem_en_d   = 1'b0;
      mem_hi_d   = 1'b0;
      issue_lo   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (num_beats == '0) begin
                  state_d = StFin;
               end else begin
                  state_d    = StRun;
                  mem_en_d   = 1'b1;
                  mem_addr_d = base_addr;
                  rd_addr_d  = base_addr + AddrOne;
                  pairs_d    = num_beats - LenOne;
                  issue_lo   = 1'b1;
               end
            end
         end
         StRun: begin
            if (mem_en_q && !mem_hi_q) begin
               mem_en_d   = 1'b1;
               mem_hi_d   = 1'b1;
               mem_addr_d = rd_addr_q;
               rd_addr_d  = rd_addr_q + AddrOne;
            end else if (pairs_q != '0) begin
               if (can_issue_lo) begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = rd_addr_q;
                  rd_addr_d  = rd_addr_q + AddrOne;
                  pairs_d    = pairs_q - LenOne;
                  issue_lo   = 1'b1;
               end
            end else begin
               // The final high-word read is on the bus this cycle.
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && count_q == 2'd1 && inflight_q == 2'd0) begin
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (issue_lo && !push) begin
         inflight_d = inflight_q + 2'd1;
      end else if (!issue_lo && push) begin
         inflight_d = inflight_q - 2'd1;
      end
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!push && pop) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         rd_addr_q  <= '0;
         mem_addr_q <= '0;
         pairs_q    <= '0;
         mem_en_q   <= 1'b0;
         mem_hi_q   <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_hi_q    <= 1'b0;
         inflight_q <= 2'd0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         mem_addr_q <= mem_addr_d;
         pairs_q    <= pairs_d;
         mem_en_q   <= mem_en_d;
         mem_hi_q   <= mem_hi_d;
         rd_vld_q   <= mem_en_q;
         rd_hi_q    <= mem_hi_q;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lo_q      <= '0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
      end else begin
         if (rd_vld_q && !rd_hi_q) begin
            lo_q <= mem_rdata;
         end
         if (push) begin
            fifo_q[wr_ptr_q] <= {mem_rdata, lo_q};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule

// File: tb/tb_ntt_ld_streamer.sv
// Directed command sequence with random SRAM contents and random kernel backpressure,
// checked against a beat-level model built from the SRAM image.
module tb_ntt_ld_streamer;

   logic          clk = 1'b0;
   logic          rstn, start, ld_rdy;
   logic [11:0]   base_addr, num_beats;
   logic          busy, done, mem_en, ld_vld;
   logic [11:0]   mem_addr;
   logic [63:0]   mem_rdata;
   logic [127:0]  ld_d;

   ntt_ld_streamer #(
      .pDATA_WIDTH(128),
      .pADDR_WIDTH(12),
      .pLEN_WIDTH (12)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .base_addr(base_addr),
      .num_beats(num_beats),
      .busy     (busy),
      .done     (done),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .ld_vld   (ld_vld),
      .ld_rdy   (ld_rdy),
      .ld_d     (ld_d)
   );

   always #5 clk = ~clk;

   logic [63:0] sram [4096];
   always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];

   int ncmp = 0, nfail = 0, cyc = 0, e0 = 0;
   int first_vld = -1, done_cyc = -1, n_en = 0, n_done = 0, n_pop = 0;
   int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: low 10 cycles after first vld, then random
   logic [127:0] exp_q[$];
   logic [11:0]  addr_log[$];
   int           hs_log[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic hs, stall;
      logic [127:0] d;
      hs    = ld_vld && ld_rdy;
      stall = ld_vld && !ld_rdy;
      d     = ld_d;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         n_pop++;
         hs_log.push_back(cyc);
         check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
         if (exp_q.size() != 0) check("beat_data", d, exp_q.pop_front());
      end
      if (stall) begin
         check("stall_vld", 128'(ld_vld), 128'(1));
         check("stall_data", ld_d, d);
      end
      if (mem_en) begin
         n_en++;
         addr_log.push_back(mem_addr);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (ld_vld && first_vld < 0) first_vld = cyc;
      case (rdy_mode)
         0:       ld_rdy = 1'b1;
         1:       ld_rdy = 1'b0;
         default: ld_rdy = (first_vld >= 0 && cyc - first_vld >= 10) ?
                           ($urandom_range(0, 1) != 0) : 1'b0;
      endcase
   endtask

   // Expected beats come straight from the SRAM image: {word[a+1], word[a]} per pair.
   task automatic launch(input logic [11:0] base, input logic [11:0] n);
      logic [11:0] a;
      exp_q.delete();
      addr_log.delete();
      hs_log.delete();
      n_en = 0; n_done = 0; n_pop = 0; first_vld = -1; done_cyc = -1;
      for (int k = 0; k < int'(n); k++) begin
         a = base + 12'(2 * k);
         exp_q.push_back({sram[a + 12'd1], sram[a]});
      end
      base_addr = base;
      num_beats = n;
      start     = 1'b1;
      tick();
      start = 1'b0;
      e0    = cyc;
      check("busy_after_start", 128'(busy), 128'(1));
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (!done && k < limit) begin
         tick();
         k++;
      end
      check("done_seen", 128'(done), 128'(1));
   endtask

   task automatic check_cmd(input int n);
      tick();
      check("busy_fall", 128'(busy), 128'(0));
      check("done_single_cycle", 128'(done), 128'(0));
      check("read_count", 128'(n_en), 128'(2 * n));
      check("done_count", 128'(n_done), 128'(1));
      check("beat_count", 128'(n_pop), 128'(n));
      check("beats_left", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      logic [11:0] wrap_exp [4];
      int k;
      rstn = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0; ld_rdy = 1'b1;
      for (int i = 0; i < 4096; i++) sram[i] = {$urandom, $urandom};
      #12;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_mem_en", 128'(mem_en), 128'(0));
      check("rst_mem_addr", 128'(mem_addr), 128'(0));
      check("rst_ld_vld", 128'(ld_vld), 128'(0));
      check("rst_ld_d", ld_d, 128'(0));
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // Basic: word[a] = a, ready held high.
      for (int i = 0; i < 32; i++) sram[i] = 64'(i);
      rdy_mode = 0;
      launch(12'h010, 12'd4);
      check("first_mem_en", 128'(mem_en), 128'(1));
      check("first_mem_addr", 128'(mem_addr), 128'(12'h010));
      tick();
      check("second_mem_addr", 128'(mem_addr), 128'(12'h011));
      wait_done(100);
      check("vld_latency", 128'(first_vld - e0 + 1), 128'(4));
      check("done_after_last_hs", 128'(done_cyc), 128'(hs_log[$]));
      for (int i = 1; i < hs_log.size(); i++)
         check("beat_spacing", 128'(hs_log[i] - hs_log[i-1]), 128'(2));
      check_cmd(4);

      // Back-to-back: start in the cycle busy has fallen.
      launch(12'h400, 12'd3);
      wait_done(100);
      check("b2b_vld_latency", 128'(first_vld - e0 + 1), 128'(4));
      check_cmd(3);

      // Backpressure: ready low for 10 cycles after first vld, then random.
      rdy_mode = 2;
      ld_rdy   = 1'b0;
      launch(12'h080, 12'd6);
      k = 0;
      while (first_vld < 0 && k < 20) begin
         tick();
         k++;
      end
      check("bp_vld_seen", 128'(first_vld >= 0), 128'(1));
      repeat (8) tick();
      check("bp_reads_stalled", 128'(n_en), 128'(4));
      check("bp_vld_held", 128'(ld_vld), 128'(1));
      wait_done(400);
      check_cmd(6);

      // Address wrap.
      rdy_mode = 0;
      ld_rdy   = 1'b1;
      launch(12'hFFE, 12'd2);
      wait_done(100);
      wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      check("wrap_addr_count", 128'(addr_log.size()), 128'(4));
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         check("wrap_addr", 128'(addr_log[i]), 128'(wrap_exp[i]));
      check_cmd(2);

      // Zero length.
      launch(12'h020, 12'd0);
      check("zero_done", 128'(done), 128'(1));
      check("zero_mem_en", 128'(mem_en), 128'(0));
      repeat (4) tick();
      check("zero_busy", 128'(busy), 128'(0));
      check("zero_reads", 128'(n_en), 128'(0));
      check("zero_no_vld", 128'(first_vld), 128'(-1));
      check("zero_done_count", 128'(n_done), 128'(1));

      // Start pulsed mid-run is ignored.
      launch(12'h200, 12'd3);
      tick();
      tick();
      base_addr = 12'h000;
      num_beats = 12'd7;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100);
      for (int i = 0; i < addr_log.size(); i++)
         check("ign_addr", 128'(addr_log[i]), 128'(12'h200 + 12'(i)));
      check_cmd(3);

      // Reset with two beats buffered.
      rdy_mode = 1;
      ld_rdy   = 1'b0;
      launch(12'h300, 12'd4);
      repeat (8) tick();
      check("pre_rst_vld", 128'(ld_vld), 128'(1));
      #2;
      rstn = 1'b0;
      #1;
      check("arst_busy", 128'(busy), 128'(0));
      check("arst_done", 128'(done), 128'(0));
      check("arst_mem_en", 128'(mem_en), 128'(0));
      check("arst_mem_addr", 128'(mem_addr), 128'(0));
      check("arst_ld_vld", 128'(ld_vld), 128'(0));
      check("arst_ld_d", ld_d, 128'(0));
      repeat (3) tick();
      check("arst_no_done", 128'(n_done), 128'(0));
      @(negedge clk);
      rstn     = 1'b1;
      rdy_mode = 0;
      ld_rdy   = 1'b1;
      tick();
      launch(12'h100, 12'd1);
      wait_done(100);
      check("post_rst_vld_latency", 128'(first_vld - e0 + 1), 128'(4));
      check_cmd(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
